// File: rtl/fc_neuron_mac.sv
// Time-multiplexed fully-connected neuron: streamed MAC over N_IN beats,
// bias add, fixed-point rescale, optional ReLU and saturated output.
module fc_neuron_mac #(
  parameter int N_IN      = 30,
  parameter int DATA_W    = 32,
  parameter int W_W       = 16,
  parameter int ACC_W     = 56,
  parameter int FRAC_BITS = 13,
  parameter int OUT_W     = 16,
  parameter bit RELU      = 1'b1,
  parameter int AW        = $clog2(N_IN+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              w_wr,
  input  logic [AW-1:0]     w_addr,
  input  logic [W_W-1:0]    w_data,
  output logic              w_drop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
);

  localparam int PW = DATA_W + W_W;

  localparam logic signed [ACC_W-1:0] MAXV =
    (ACC_W'(1) <<< (OUT_W-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MINV =
    -MAXV - ACC_W'(1);

  typedef enum logic [1:0] {
    S_ACCUM,
    S_FINAL,
    S_OUT
  } state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            count_q, count_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     w_drop_q, w_drop_d;

  // entries 0..N_IN-1 hold weights, entry N_IN holds the bias
  logic signed [W_W-1:0]    wmem_q [N_IN+1];

  logic                     beat;
  logic                     wr_ok;
  logic signed [W_W-1:0]    w_cur;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shr;
  logic [OUT_W-1:0]         res;

  // datapath: product, bias add, rescale and output clamp
  always_comb begin
    w_cur = wmem_q[count_q];
    prod  = $signed(in_data) * w_cur;
    sum   = acc_q + ACC_W'(wmem_q[N_IN]);
    shr   = sum >>> FRAC_BITS;
    res   = shr[OUT_W-1:0];
    if (shr > MAXV)
      res = MAXV[OUT_W-1:0];
    else if (shr < MINV)
      res = MINV[OUT_W-1:0];
    if (RELU && shr < 0)
      res = '0;
  end

  // handshake, write qualification and next-state logic
  always_comb begin
    in_ready = (state_q == S_ACCUM) & ~reset & ~flush;
    beat     = in_valid & in_ready;
    wr_ok    = w_wr & ~reset & ~flush
             & (state_q == S_ACCUM)
             & (count_q == '0)
             & (w_addr <= AW'(N_IN));
    w_drop_d = w_wr & ~wr_ok;

    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      S_ACCUM: begin
        if (beat) begin
          acc_d = acc_q + ACC_W'(prod);
          if (count_q == AW'(N_IN-1)) begin
            count_d = '0;
            state_d = S_FINAL;
          end else begin
            count_d = count_q + AW'(1);
          end
        end
      end
      S_FINAL: begin
        out_data_d  = res;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = S_ACCUM;
        end
      end
      default: state_d = S_ACCUM;
    endcase

    if (flush) begin
      state_d     = S_ACCUM;
      count_d     = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end
  end

  // control and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_ACCUM;
      count_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      w_drop_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      w_drop_q    <= w_drop_d;
    end
  end

  // weight/bias storage survives reset
  always_ff @(posedge clk) begin
    if (wr_ok)
      wmem_q[w_addr] <= w_data;
  end

  assign w_drop    = w_drop_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fc_neuron_mac.sv
// Directed bench for fc_neuron_mac with N_IN=4; a ReLU and a
// non-ReLU instance share every input.
module tb_fc_neuron_mac;

  localparam int N_IN = 4;
  localparam int AW   = 3;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, w_wr, out_ready;
  logic [31:0] in_data;
  logic [AW-1:0] w_addr;
  logic [15:0] w_data;

  logic        in_ready, w_drop, out_valid;
  logic [15:0] out_data;
  logic        in_ready0, w_drop0, out_valid0;
  logic [15:0] out_data0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fc_neuron_mac #(.N_IN(N_IN), .RELU(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_wr(w_wr), .w_addr(w_addr), .w_data(w_data), .w_drop(w_drop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  fc_neuron_mac #(.N_IN(N_IN), .RELU(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .w_wr(w_wr), .w_addr(w_addr), .w_data(w_data), .w_drop(w_drop0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0)
  );

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int a, input int d, input bit drop);
    w_wr   = 1'b1;
    w_addr = AW'(a);
    w_data = 16'(d);
    tick();
    w_wr = 1'b0;
    chk("w_drop", w_drop, drop);
  endtask

  task automatic load(input int w, input int b);
    for (int i = 0; i < N_IN; i++)
      write_w(i, w, 1'b0);
    write_w(N_IN, b, 1'b0);
  endtask

  task automatic send(input int d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = 32'(d);
    #1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20)
      chk("rdy_timeout", n, 0);
    tick();
    in_valid = 1'b0;
  endtask

  // after the last accept: FINAL cycle first, result the cycle after
  task automatic result(input string tag, input int e1, input int e0);
    chk({tag, "_lat0"}, out_valid, 0);
    tick();
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_relu"}, $signed(out_data), e1);
    chk({tag, "_lin"}, $signed(out_data0), e0);
    tick();
  endtask

  task automatic frame(input int a, input int b,
                       input int c, input int d,
                       input string tag, input int e1, input int e0);
    send(a); send(b); send(c); send(d);
    result(tag, e1, e0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    w_wr = 1'b0; w_addr = '0; w_data = '0; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 0);
    chk("rst_wd", w_drop, 0);
    chk("rst_rdy", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("rdy_after_rst", in_ready, 1);

    load(8192, 0);
    frame(1, 2, 3, 4, "basic", 10, 10);

    load(8192, -24576);
    frame(1, 2, 3, 4, "bias", 7, 7);

    load(-8192, 0);
    frame(1, 2, 3, 4, "neg", 0, -10);

    load(8192, 0);
    frame(1 << 20, 1 << 20, 1 << 20, 1 << 20, "sat_hi", 32767, 32767);

    load(-8192, 0);
    frame(1 << 20, 1 << 20, 1 << 20, 1 << 20, "sat_lo", 0, -32768);

    load(8192, 0);
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", out_valid, 1);
      chk("bp_data", out_data, 10);
      chk("bp_rdy", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_resume_rdy", in_ready, 1);
    frame(4, 4, 4, 4, "bp_next", 16, 16);

    send(9); send(9);
    flush = 1'b1;
    #1;
    chk("flush_rdy", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("flush_ov", out_valid, 0);
    frame(1, 2, 3, 4, "post_flush", 10, 10);

    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd100;
    #1;
    chk("flush_beat_rdy", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    frame(1, 2, 3, 4, "flush_beat", 10, 10);

    send(1); send(2);
    w_wr = 1'b1; w_addr = '0; w_data = '0;
    tick();
    w_wr = 1'b0;
    chk("drop_mid", w_drop, 1);
    tick();
    chk("drop_pulse_end", w_drop, 0);
    send(3); send(4);
    result("drop_frame", 10, 10);
    frame(1, 2, 3, 4, "w0_kept", 10, 10);

    write_w(5, 123, 1'b1);
    tick();
    chk("drop_addr_end", w_drop, 0);

    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    tick();
    chk("pre_rst_ov", out_valid, 1);
    reset = 1'b1;
    tick();
    chk("rst_out_ov", out_valid, 0);
    chk("rst_out_od", out_data, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    frame(1, 2, 3, 4, "post_rst", 10, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
